// File: rtl/pe_net_if_pkg.sv
// Shared flit geometry and drop-counter definitions for the PE network interface.
package pe_net_if_pkg;

  // Default flit layout: {dest[AddrWidth-1:0], payload}.
  localparam int DefDataWidth = 34;
  localparam int DefAddrWidth = 2;

  // The drop counter saturates, so it can never wrap back to a small value.
  localparam int DropCntWidth = 8;
  localparam logic [DropCntWidth-1:0] DropCntMax = 8'd255;

  typedef logic [DropCntWidth-1:0] dropCnt_t;

  // The payload occupies the low bits below the dest field. This value is
  // also the bit offset of the dest field's LSB.
  function automatic int payloadWidth(int dataWidth, int addrWidth);
    return dataWidth - addrWidth;
  endfunction

endpackage

// File: rtl/pe_net_if_sync_fifo.sv
// Single-clock valid/ready FIFO. It has registered outputs only, so there is no
// combinational path from push to pop. The storage array is not reset.
module sync_fifo #(
  parameter int Width = 8,
  parameter int Depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pushValid,
  output logic             pushReady,
  input  logic [Width-1:0] pushData,
  output logic             popValid,
  input  logic             popReady,
  output logic [Width-1:0] popData
);

  localparam int PtrW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wrPtr;
  logic [PtrW-1:0]  rdPtr;
  logic [PtrW:0]    count;
  logic             doPush;
  logic             doPop;

  assign pushReady = (count != (PtrW+1)'(Depth));
  assign popValid  = (count != '0);
  assign popData   = mem[rdPtr];
  assign doPush    = pushValid & pushReady;
  assign doPop     = popValid & popReady;

  // Storage write. The array is left unreset because its contents are never
  // observable while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
    end
  end

  // Occupancy tracking. A simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pe_net_if.sv
// Leaf network interface for one PE. TX buffers PE words as addressed flits.
// RX keeps flits addressed to this leaf and counts the flits it discards.
module pe_net_if
  import pe_net_if_pkg::*;
#(
  parameter int DataWidth = DefDataWidth,
  parameter int AddrWidth = DefAddrWidth,
  parameter int MyAddr    = 0,
  parameter int FifoDepth = 4
) (
  input  logic                                i_sclk,
  input  logic                                i_reset,
  input  logic [DataWidth-AddrWidth-1:0]      i_pe_data,
  input  logic [AddrWidth-1:0]                i_pe_dest,
  input  logic                                i_pe_valid,
  output logic                                o_pe_ready,
  output logic [DataWidth-AddrWidth-1:0]      o_pe_data,
  output logic                                o_pe_valid,
  input  logic                                i_pe_ready,
  output logic [DataWidth-1:0]                o_net_data,
  output logic                                o_net_valid,
  input  logic                                i_net_ready,
  input  logic [DataWidth-1:0]                i_net_data,
  input  logic                                i_net_valid,
  output logic                                o_net_ready,
  output logic [DropCntWidth-1:0]             o_drop_count
);

  localparam int PayloadWidth = payloadWidth(DataWidth, AddrWidth);

  logic [AddrWidth-1:0] netDest;
  logic                 netForMe;
  logic                 rxPushValid;
  logic                 dropEvent;
  dropCnt_t             dropCount;

  assign netDest     = i_net_data[DataWidth-1 -: AddrWidth];
  assign netForMe    = (netDest == AddrWidth'(MyAddr));
  assign rxPushValid = i_net_valid & netForMe;
  // A foreign flit is consumed only under the same ready that gates RX
  // writes, so the tree sees a single consistent ready.
  assign dropEvent   = i_net_valid & o_net_ready & ~netForMe;

  sync_fifo #(
    .Width (DataWidth),
    .Depth (FifoDepth)
  ) txFifo (
    .clk       (i_sclk),
    .rst       (i_reset),
    .pushValid (i_pe_valid),
    .pushReady (o_pe_ready),
    .pushData  ({i_pe_dest, i_pe_data}),
    .popValid  (o_net_valid),
    .popReady  (i_net_ready),
    .popData   (o_net_data)
  );

  // Only the payload is kept on RX. The dest field of a stored flit always
  // equals MyAddr, so storing it would carry no information.
  sync_fifo #(
    .Width (PayloadWidth),
    .Depth (FifoDepth)
  ) rxFifo (
    .clk       (i_sclk),
    .rst       (i_reset),
    .pushValid (rxPushValid),
    .pushReady (o_net_ready),
    .pushData  (i_net_data[PayloadWidth-1:0]),
    .popValid  (o_pe_valid),
    .popReady  (i_pe_ready),
    .popData   (o_pe_data)
  );

  // Saturating count of flits that were addressed to other leaves.
  always_ff @(posedge i_sclk or posedge i_reset) begin
    if (i_reset) begin
      dropCount <= '0;
    end else if (dropEvent && (dropCount != DropCntMax)) begin
      dropCount <= dropCount + 1'b1;
    end
  end

  assign o_drop_count = dropCount;

endmodule

// File: tb/tb_pe_net_if.sv
module tb_pe_net_if;

  localparam int DW = 34;
  localparam int AW = 2;
  localparam int PW = DW - AW;

  logic          i_sclk = 1'b0;
  logic          i_reset;
  logic [PW-1:0] i_pe_data;
  logic [AW-1:0] i_pe_dest;
  logic          i_pe_valid;
  logic          o_pe_ready;
  logic [PW-1:0] o_pe_data;
  logic          o_pe_valid;
  logic          i_pe_ready;
  logic [DW-1:0] o_net_data;
  logic          o_net_valid;
  logic          i_net_ready;
  logic [DW-1:0] i_net_data;
  logic          i_net_valid;
  logic          o_net_ready;
  logic [7:0]    o_drop_count;

  int checks = 0;
  int errors = 0;

  pe_net_if #(
    .DataWidth (DW),
    .AddrWidth (AW),
    .MyAddr    (1),
    .FifoDepth (4)
  ) dut (
    .i_sclk       (i_sclk),
    .i_reset      (i_reset),
    .i_pe_data    (i_pe_data),
    .i_pe_dest    (i_pe_dest),
    .i_pe_valid   (i_pe_valid),
    .o_pe_ready   (o_pe_ready),
    .o_pe_data    (o_pe_data),
    .o_pe_valid   (o_pe_valid),
    .i_pe_ready   (i_pe_ready),
    .o_net_data   (o_net_data),
    .o_net_valid  (o_net_valid),
    .i_net_ready  (i_net_ready),
    .i_net_data   (i_net_data),
    .i_net_valid  (i_net_valid),
    .o_net_ready  (o_net_ready),
    .o_drop_count (o_drop_count)
  );

  always #5 i_sclk = ~i_sclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic          pv;
    logic [1:0]    pd;
    logic [31:0]   pdat;
    logic          nr;
    logic          nv;
    logic [33:0]   nd;
    logic          pr;
    logic          eNv;
    logic [33:0]   eNd;
    logic          ePr;
    logic          ePv;
    logic [31:0]   ePd;
    logic          eNr;
    logic [7:0]    eDrop;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_sclk);
    #1;
  endtask

  task automatic idle();
    i_pe_valid  = 1'b0;
    i_pe_dest   = '0;
    i_pe_data   = '0;
    i_net_valid = 1'b0;
    i_net_data  = '0;
  endtask

  task automatic chkResetVals(input string tag);
    chk({tag, "NetValid"}, o_net_valid, 1'b0);
    chk({tag, "PeValid"},  o_pe_valid,  1'b0);
    chk({tag, "PeReady"},  o_pe_ready,  1'b1);
    chk({tag, "NetReady"}, o_net_ready, 1'b1);
    chk({tag, "Drop"},     o_drop_count, 8'd0);
  endtask

  function automatic vec_t mkVec(
    logic pv, logic [1:0] pd, logic [31:0] pdat, logic nr,
    logic nv, logic [33:0] nd, logic pr,
    logic eNv, logic [33:0] eNd, logic ePr, logic ePv, logic [31:0] ePd,
    logic eNr, logic [7:0] eDrop);
    vec_t v;
    v.pv = pv; v.pd = pd; v.pdat = pdat; v.nr = nr;
    v.nv = nv; v.nd = nd; v.pr = pr;
    v.eNv = eNv; v.eNd = eNd; v.ePr = ePr; v.ePv = ePv; v.ePd = ePd;
    v.eNr = eNr; v.eDrop = eDrop;
    return v;
  endfunction

  initial begin
    int bad;
    logic [7:0] expDrop;

    // TX: five words to dest 2 with the network stalled, then released.
    vecs.push_back(mkVec(1, 2, 32'h1, 0, 0, 34'h0, 0,  1, 34'h2_0000_0001, 1, 0, 32'h0, 1, 8'd0));
    vecs.push_back(mkVec(1, 2, 32'h2, 0, 0, 34'h0, 0,  1, 34'h2_0000_0001, 1, 0, 32'h0, 1, 8'd0));
    vecs.push_back(mkVec(1, 2, 32'h3, 0, 0, 34'h0, 0,  1, 34'h2_0000_0001, 1, 0, 32'h0, 1, 8'd0));
    vecs.push_back(mkVec(1, 2, 32'h4, 0, 0, 34'h0, 0,  1, 34'h2_0000_0001, 0, 0, 32'h0, 1, 8'd0));
    vecs.push_back(mkVec(1, 2, 32'h5, 0, 0, 34'h0, 0,  1, 34'h2_0000_0001, 0, 0, 32'h0, 1, 8'd0));
    vecs.push_back(mkVec(1, 2, 32'h5, 1, 0, 34'h0, 0,  1, 34'h2_0000_0002, 1, 0, 32'h0, 1, 8'd0));
    vecs.push_back(mkVec(1, 2, 32'h5, 1, 0, 34'h0, 0,  1, 34'h2_0000_0003, 1, 0, 32'h0, 1, 8'd0));
    vecs.push_back(mkVec(0, 0, 32'h0, 1, 0, 34'h0, 0,  1, 34'h2_0000_0004, 1, 0, 32'h0, 1, 8'd0));
    vecs.push_back(mkVec(0, 0, 32'h0, 1, 0, 34'h0, 0,  1, 34'h2_0000_0005, 1, 0, 32'h0, 1, 8'd0));
    vecs.push_back(mkVec(0, 0, 32'h0, 1, 0, 34'h0, 0,  0, 34'h0,           1, 0, 32'h0, 1, 8'd0));
    // RX: own flit, foreign flit, pass-through, drain, another foreign flit.
    vecs.push_back(mkVec(0, 0, 32'h0, 0, 1, 34'h1_DEAD_BEEF, 0,  0, 34'h0, 1, 1, 32'hDEAD_BEEF, 1, 8'd0));
    vecs.push_back(mkVec(0, 0, 32'h0, 0, 1, 34'h3_0000_0011, 0,  0, 34'h0, 1, 1, 32'hDEAD_BEEF, 1, 8'd1));
    vecs.push_back(mkVec(0, 0, 32'h0, 0, 1, 34'h1_0000_0022, 1,  0, 34'h0, 1, 1, 32'h0000_0022, 1, 8'd1));
    vecs.push_back(mkVec(0, 0, 32'h0, 0, 0, 34'h0,           1,  0, 34'h0, 1, 0, 32'h0,         1, 8'd1));
    vecs.push_back(mkVec(0, 0, 32'h0, 0, 1, 34'h0_0000_0033, 0,  0, 34'h0, 1, 0, 32'h0,         1, 8'd2));
    // TX and RX in the same cycle, then both drained.
    vecs.push_back(mkVec(1, 0, 32'hAA, 0, 1, 34'h1_0000_0044, 0,  1, 34'h0_0000_00AA, 1, 1, 32'h44, 1, 8'd2));
    vecs.push_back(mkVec(0, 0, 32'h0,  1, 0, 34'h0,           1,  0, 34'h0,           1, 0, 32'h0,  1, 8'd2));

    idle();
    i_pe_ready  = 1'b0;
    i_net_ready = 1'b0;
    i_reset     = 1'b1;
    #3;
    chkResetVals("rstDuring");
    tick();
    tick();
    i_reset = 1'b0;
    tick();
    chkResetVals("rstAfter");

    foreach (vecs[i]) begin
      i_pe_valid  = vecs[i].pv;
      i_pe_dest   = vecs[i].pd;
      i_pe_data   = vecs[i].pdat;
      i_net_ready = vecs[i].nr;
      i_net_valid = vecs[i].nv;
      i_net_data  = vecs[i].nd;
      i_pe_ready  = vecs[i].pr;
      tick();
      chk($sformatf("v%0d netValid", i), o_net_valid, vecs[i].eNv);
      if (vecs[i].eNv) chk($sformatf("v%0d netData", i), o_net_data, vecs[i].eNd);
      chk($sformatf("v%0d peReady", i), o_pe_ready, vecs[i].ePr);
      chk($sformatf("v%0d peValid", i), o_pe_valid, vecs[i].ePv);
      if (vecs[i].ePv) chk($sformatf("v%0d peData", i), o_pe_data, vecs[i].ePd);
      chk($sformatf("v%0d netReady", i), o_net_ready, vecs[i].eNr);
      chk($sformatf("v%0d drop", i), o_drop_count, vecs[i].eDrop);
    end

    // RX full: ready falls after the fourth flit and the stored data is held.
    idle();
    i_pe_ready  = 1'b0;
    i_net_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      i_net_valid = 1'b1;
      i_net_data  = {2'd1, 32'h100 + 32'(i)};
      tick();
      chk($sformatf("rxFullReady%0d", i), o_net_ready, (i < 3) ? 1'b1 : 1'b0);
    end
    chk("rxFullDrop", o_drop_count, 8'd2);
    idle();
    i_pe_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("rxDrainValid", o_pe_valid, 1'b1);
      chk($sformatf("rxDrainData%0d", i), o_pe_data, 32'h100 + 32'(i));
      tick();
    end
    chk("rxDrainEmpty", o_pe_valid, 1'b0);

    // Half-full RX with a push and a pop every cycle.
    i_pe_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      i_net_valid = 1'b1;
      i_net_data  = {2'd1, 32'(k)};
      tick();
    end
    i_pe_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      i_net_valid = 1'b1;
      i_net_data  = {2'd1, 32'(k + 2)};
      chk("steadyValid", o_pe_valid, 1'b1);
      chk($sformatf("steadyData%0d", k), o_pe_data, 32'(k));
      chk("steadyNetReady", o_net_ready, 1'b1);
      tick();
    end
    idle();
    chk("steadyTail20", o_pe_data, 32'd20);
    tick();
    chk("steadyTail21", o_pe_data, 32'd21);
    tick();
    chk("steadyEmpty", o_pe_valid, 1'b0);

    // Reset asserted between clock edges while both FIFOs hold three words.
    i_pe_ready  = 1'b0;
    i_net_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_pe_valid  = 1'b1;
      i_pe_dest   = 2'd3;
      i_pe_data   = 32'h50 + 32'(i);
      i_net_valid = 1'b1;
      i_net_data  = {2'd1, 32'h60 + 32'(i)};
      tick();
    end
    chk("preRstNetValid", o_net_valid, 1'b1);
    chk("preRstPeValid", o_pe_valid, 1'b1);
    chk("preRstDrop", o_drop_count, 8'd2);
    #2;
    i_reset = 1'b1;
    #1;
    chkResetVals("rstAsync");
    tick();
    chkResetVals("rstHeld");
    i_reset = 1'b0;
    i_pe_valid  = 1'b1;
    i_pe_dest   = 2'd1;
    i_pe_data   = 32'h77;
    i_net_valid = 1'b1;
    i_net_data  = {2'd1, 32'h88};
    tick();
    idle();
    chk("postRstNetData", o_net_data, {2'd1, 32'h77});
    chk("postRstPeData", o_pe_data, 32'h88);
    i_pe_ready  = 1'b1;
    i_net_ready = 1'b1;
    tick();
    chk("postRstNetEmpty", o_net_valid, 1'b0);
    chk("postRstPeEmpty", o_pe_valid, 1'b0);

    // 300 foreign flits: never stalled, never delivered, count saturates.
    bad = 0;
    for (int k = 1; k <= 300; k++) begin
      i_net_valid = 1'b1;
      i_net_data  = {2'd3, 32'(k)};
      if (o_net_ready !== 1'b1) bad++;
      tick();
      expDrop = (k > 255) ? 8'd255 : 8'(k);
      if (o_pe_valid !== 1'b0 || o_drop_count !== expDrop) bad++;
      if (k == 254) chk("drop254", o_drop_count, 8'd254);
      if (k == 255) chk("drop255", o_drop_count, 8'd255);
    end
    idle();
    chk("dropBadCycles", 64'(bad), 64'd0);
    chk("dropFinal", o_drop_count, 8'd255);
    chk("dropPeValid", o_pe_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_net_if.md
PE_NET_IF -- requirements
Module: pe_net_if

Interface
REQ-001 Parameter DataWidth, default 34, network flit width: {dest[AddrWidth-1:0], payload}.
REQ-002 Parameter AddrWidth, default 2, destination field width occupying flit bits [DataWidth-1 -: AddrWidth].
REQ-003 Parameter MyAddr, default 0, the leaf address of the attached PE.
REQ-004 Parameter FifoDepth, default 4, power of two >= 2, depth of each of the TX and RX FIFOs.
REQ-005 i_sclk  in  1  sole clock; all state updates on its rising edge.
REQ-006 i_reset  in  1  reset, asynchronous, active-high.
REQ-007 i_pe_data  in  DataWidth-AddrWidth  PE payload to send.
REQ-008 i_pe_dest  in  AddrWidth  destination leaf address for i_pe_data.
REQ-009 i_pe_valid / o_pe_ready  in / out  1  PE-to-interface handshake.
REQ-010 o_pe_data  out  DataWidth-AddrWidth  received payload to PE; o_pe_valid out 1, i_pe_ready in 1.
REQ-011 o_net_data  out  DataWidth  flit to tree leaf port; o_net_valid out 1, i_net_ready in 1.
REQ-012 i_net_data  in  DataWidth  flit from tree leaf port; i_net_valid in 1, o_net_ready out 1.
REQ-013 o_drop_count  out  8  count of received flits whose dest differs from MyAddr.

Function
REQ-014 Every handshake transfers exactly one word in a cycle where valid and ready are both high at the clock edge; no other cycle transfers.
REQ-015 TX path: accepted PE word is written into TX FIFO as {i_pe_dest, i_pe_data}.
REQ-016 o_pe_ready = TX FIFO not full; o_net_valid = TX FIFO not empty; o_net_data = TX FIFO head.
REQ-017 RX path: o_net_ready = RX FIFO not full; accepted flit with dest == MyAddr is written into RX FIFO.
REQ-018 Accepted flit with dest != MyAddr is consumed (not stored) and o_drop_count increments by 1, saturating at 255.
REQ-019 o_pe_valid = RX FIFO not empty; o_pe_data = payload field (low DataWidth-AddrWidth bits) of RX FIFO head.
REQ-020 Latency: word written at edge N is visible at FIFO output after edge N (one-cycle write-to-read); no combinational valid-to-ready or data passthrough.
REQ-021 Full FIFO: ready low, no write, stored contents unchanged; push and pop in same cycle while full is impossible (ready low), pop proceeds.
REQ-022 Empty FIFO: valid low, output data don't-care; simultaneous push into empty FIFO yields valid high the next cycle.
REQ-023 Simultaneous push and pop on non-full, non-empty FIFO: occupancy unchanged, order preserved.
REQ-024 Read/write pointers are log2(FifoDepth) bits and wrap modulo FifoDepth; occupancy counter is log2(FifoDepth)+1 bits.
REQ-025 Order within each FIFO is strictly FIFO; TX and RX paths are fully independent and may transfer in the same cycle.
REQ-026 Valid, once asserted by this block, is held with stable data until accepted.

Reset
REQ-027 i_reset asserted at any time, including mid-transfer, immediately clears both FIFOs (pointers, counts) and o_drop_count to 0.
REQ-028 During and after reset until first write: o_net_valid=0, o_pe_valid=0, o_pe_ready=1, o_net_ready=1, o_drop_count=0.
REQ-029 FIFO storage RAM is not reset; contents are unobservable while empty.

Structure
REQ-030 Shared package holds flit field widths/offsets, dest-field extraction constant, and drop-counter width (8) and maximum (255).
REQ-031 One sub-module sync_fifo (parameters Width, Depth; push/pop valid-ready ports, async active-high reset) instantiated twice, for TX and RX.

Verification
REQ-032 PE sends 5 words dest=2, payload 0x1..0x5, i_net_ready=0 -> 4 accepted, o_pe_ready=0 on 5th; release -> o_net_data = {2'd2, 0x1}..{2'd2, 0x4}, then 0x5, in order.
REQ-033 MyAddr=1, tree sends flit {2'd1, 0xDEADBEEF} -> o_pe_valid high next cycle, o_pe_data=0xDEADBEEF, o_drop_count=0.
REQ-034 Tree sends 300 flits dest=3 to MyAddr=0 -> none reach PE, o_drop_count=255, o_net_ready never low.
REQ-035 RX FIFO half full, push and pop every cycle for 20 cycles -> occupancy constant at 2, sequence 0..19 delivered in order.
REQ-036 Reset asserted asynchronously mid-burst with both FIFOs holding 3 words -> outputs immediately take REQ-028 values; post-reset traffic unaffected by stale data.
